// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared encodings and defaults for the memory port arbiter
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2
  } state_e;

  localparam logic OWN_INST = 1'b0;
  localparam logic OWN_DATA = 1'b1;

  localparam int TIMEOUT_DEF = 255;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// rtl/mem_arbiter_rr_arb2.sv - two-way round-robin picker; bit 0 = instruction, bit 1 = data
module rr_arb2
  import mem_arbiter_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = req_i;
    if (req_i[0] && req_i[1]) begin
      gnt_o = (last_i == OWN_INST) ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one SRAM-like port between instruction fetch and data access
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_gnt,
  output logic          i_done,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic [3:0]    d_wen,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_done,
  output logic [DW-1:0] d_rdata,
  output logic          m_req,
  output logic          m_wr,
  output logic [3:0]    m_wstrb,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic          m_addr_ok,
  input  logic          m_data_ok,
  input  logic [DW-1:0] m_rdata,
  output logic          err
);

  localparam logic [15:0] TO_CNT = 16'(TIMEOUT);

  state_e        state_q, state_d;
  logic          owner_q, owner_d;
  logic          last_q, last_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          wr_q, wr_d;
  logic [3:0]    wstrb_q, wstrb_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          i_done_q, i_done_d, d_done_q, d_done_d, err_q, err_d;
  logic [DW-1:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  logic [1:0]    gnt;
  logic          complete, abort;

  rr_arb2 u_rr (
    .req_i  ({d_req, i_req}),
    .last_i (last_q),
    .gnt_o  (gnt)
  );

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wr_d      = wr_q;
    wstrb_d   = wstrb_q;
    wdata_d   = wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    i_done_d  = 1'b0;
    d_done_d  = 1'b0;
    err_d     = 1'b0;
    i_gnt     = 1'b0;
    d_gnt     = 1'b0;
    m_req     = 1'b0;
    complete  = 1'b0;
    abort     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (|gnt) begin
          state_d = S_ADDR;
          cnt_d   = '0;
          owner_d = gnt[1];
          last_d  = gnt[1];
          if (gnt[1]) begin
            d_gnt   = 1'b1;
            addr_d  = d_addr;
            wr_d    = |d_wen;
            wstrb_d = d_wen;
            wdata_d = d_wdata;
          end else begin
            i_gnt   = 1'b1;
            addr_d  = i_addr;
            wr_d    = 1'b0;
            wstrb_d = 4'h0;
            wdata_d = '0;
          end
        end
      end
      S_ADDR: begin
        m_req = 1'b1;
        cnt_d = cnt_q + 16'd1;
        // data_ok only counts here when the address is accepted in the same cycle
        if (m_addr_ok && m_data_ok) complete = 1'b1;
        else if (cnt_q == TO_CNT)   abort    = 1'b1;
        else if (m_addr_ok)         state_d  = S_DATA;
      end
      S_DATA: begin
        cnt_d = cnt_q + 16'd1;
        if (m_data_ok)            complete = 1'b1;
        else if (cnt_q == TO_CNT) abort    = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (complete) begin
      state_d = S_IDLE;
      if (owner_q == OWN_DATA) begin
        d_done_d = 1'b1;
        if (!wr_q) d_rdata_d = m_rdata;
      end else begin
        i_done_d  = 1'b1;
        i_rdata_d = m_rdata;
      end
    end

    if (abort) begin
      state_d = S_IDLE;
      err_d   = 1'b1;
      if (owner_q == OWN_DATA) begin
        d_done_d  = 1'b1;
        d_rdata_d = '0;
      end else begin
        i_done_d  = 1'b1;
        i_rdata_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      owner_q   <= OWN_INST;
      last_q    <= OWN_INST;
      cnt_q     <= '0;
      addr_q    <= '0;
      wr_q      <= 1'b0;
      wstrb_q   <= 4'h0;
      wdata_q   <= '0;
      i_done_q  <= 1'b0;
      d_done_q  <= 1'b0;
      err_q     <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wr_q      <= wr_d;
      wstrb_q   <= wstrb_d;
      wdata_q   <= wdata_d;
      i_done_q  <= i_done_d;
      d_done_q  <= d_done_d;
      err_q     <= err_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  assign m_addr  = addr_q;
  assign m_wr    = wr_q;
  assign m_wstrb = wstrb_q;
  assign m_wdata = wdata_q;
  assign i_done  = i_done_q;
  assign d_done  = d_done_q;
  assign err     = err_q;
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed scoreboard bench for mem_arbiter
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_req, m_addr_ok, m_data_ok;
  logic [31:0] i_addr, d_addr, d_wdata, m_rdata;
  logic [3:0]  d_wen;
  logic        i_gnt, i_done, d_gnt, d_done, m_req, m_wr, err;
  logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
  logic [3:0]  m_wstrb;

  typedef struct packed {
    logic        is_d;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [31:0] exp_d_rdata;
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.AW(32), .DW(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_done(i_done), .i_rdata(i_rdata),
    .d_req(d_req), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_done(d_done), .d_rdata(d_rdata),
    .m_req(m_req), .m_wr(m_wr), .m_wstrb(m_wstrb), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata), .err(err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (i_done || d_done) begin
        if (sb.size() == 0) begin
          chk("spurious_done", 64'({d_done, i_done}), 64'(0));
        end else begin
          mon_e = sb.pop_front();
          chk("done_owner", 64'({d_done, i_done}), 64'(mon_e.is_d ? 2'b10 : 2'b01));
          chk("done_rdata", 64'(mon_e.is_d ? d_rdata : i_rdata), 64'(mon_e.rdata));
          chk("done_err", 64'(err), 64'(mon_e.err));
        end
      end else if (err) begin
        chk("err_without_done", 64'(err), 64'(0));
      end
    end
  end

  task automatic do_txn(input bit is_d, input logic [3:0] wen, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rdata, input int gap);
    exp_t e;
    @(posedge clk); #1;
    if (is_d) begin
      d_req = 1'b1; d_wen = wen; d_addr = addr; d_wdata = wdata;
    end else begin
      i_req = 1'b1; i_addr = addr;
    end
    @(negedge clk);
    chk("gnt", 64'({d_gnt, i_gnt}), 64'(is_d ? 2'b10 : 2'b01));
    e.is_d = is_d;
    e.err  = 1'b0;
    e.rdata = (is_d && wen != 4'h0) ? exp_d_rdata : rdata;
    if (is_d && wen == 4'h0) exp_d_rdata = rdata;
    sb.push_back(e);
    @(posedge clk); #1;
    i_req = 1'b0; d_req = 1'b0;
    i_addr = 32'hDEAD_0000; d_addr = 32'hDEAD_0004; d_wdata = 32'hFFFF_FFFF; d_wen = 4'hA;
    m_addr_ok = 1'b1; m_data_ok = (gap == 0);
    m_rdata = (gap == 0) ? rdata : 32'h0BAD_0BAD;
    @(negedge clk);
    chk("m_req_addr", 64'(m_req), 64'(1));
    chk("m_addr", 64'(m_addr), 64'(addr));
    chk("m_wr", 64'(m_wr), 64'(is_d && wen != 4'h0));
    chk("m_wstrb", 64'(m_wstrb), 64'(is_d ? wen : 4'h0));
    if (is_d) chk("m_wdata", 64'(m_wdata), 64'(wdata));
    for (int k = 0; k < gap; k++) begin
      @(posedge clk); #1;
      m_addr_ok = 1'b0;
      m_data_ok = (k == gap - 1);
      m_rdata   = (k == gap - 1) ? rdata : 32'h0BAD_0BAD;
      @(negedge clk);
      chk("m_req_data", 64'(m_req), 64'(0));
    end
    @(posedge clk); #1;
    m_addr_ok = 1'b0; m_data_ok = 1'b0; m_rdata = 32'h0;
    @(negedge clk);
    chk("done_latency", 64'(is_d ? d_done : i_done), 64'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    rst = 1'b0;
    i_req = 1'b0; d_req = 1'b0; m_addr_ok = 1'b0; m_data_ok = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0; m_rdata = '0; d_wen = '0;
    exp_d_rdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt", 64'({i_gnt, d_gnt}), 64'(0));
    chk("rst_done_err", 64'({i_done, d_done, err}), 64'(0));
    chk("rst_mem", 64'({m_req, m_wr, m_wstrb}), 64'(0));
    chk("rst_maddr", 64'(m_addr), 64'(0));
    chk("rst_mwdata", 64'(m_wdata), 64'(0));
    chk("rst_rdata", 64'({i_rdata, d_rdata}), 64'(0));

    // both requesters active from reset release, zero-wait memory
    @(posedge clk); #1;
    rst = 1'b1;
    i_req = 1'b1; d_req = 1'b1; d_wen = 4'h0; i_addr = 32'h100; d_addr = 32'h200;
    m_addr_ok = 1'b1; m_data_ok = 1'b1; m_rdata = 32'h1000;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
        m_rdata = 32'h1000 + 32'(k);
      end
      @(negedge clk);
      if (k % 2 == 0) begin
        chk("alt_gnt", 64'({d_gnt, i_gnt}), 64'((k % 4 == 0) ? 2'b10 : 2'b01));
        e.is_d  = (k % 4 == 0);
        e.rdata = 32'h1000 + 32'(k + 1);
        e.err   = 1'b0;
        if (e.is_d) exp_d_rdata = e.rdata;
        sb.push_back(e);
      end else begin
        chk("alt_gnt_addr", 64'({d_gnt, i_gnt}), 64'(0));
      end
      chk("alt_done", 64'({d_done, i_done}),
          64'((k % 2 == 0 && k >= 2) ? (((k - 2) % 4 == 0) ? 2'b10 : 2'b01) : 2'b00));
    end
    @(posedge clk); #1;
    i_req = 1'b0; d_req = 1'b0; m_addr_ok = 1'b0; m_data_ok = 1'b0; m_rdata = '0;
    @(negedge clk);
    chk("alt_tail_gnt", 64'({d_gnt, i_gnt}), 64'(0));
    chk("alt_tail_done", 64'({d_done, i_done}), 64'(2'b01));

    do_txn(1'b0, 4'h0, 32'hBFC0_0000, 32'h0, 32'h2402_0005, 2);
    do_txn(1'b1, 4'b0100, 32'd80, 32'h00AB_0000, 32'h0, 0);
    do_txn(1'b1, 4'b0000, 32'd80, 32'h0, 32'hCAFE_F00D, 1);
    do_txn(1'b1, 4'b1111, 32'd84, 32'd7, 32'h0, 1);

    // address accepted, data never returns: abort after TIMEOUT
    @(posedge clk); #1;
    d_req = 1'b1; d_wen = 4'h0; d_addr = 32'h40;
    @(negedge clk);
    chk("to_gnt", 64'(d_gnt), 64'(1));
    e.is_d = 1'b1; e.rdata = 32'h0; e.err = 1'b1;
    exp_d_rdata = 32'h0;
    sb.push_back(e);
    @(posedge clk); #1;
    d_req = 1'b0; m_addr_ok = 1'b1;
    @(negedge clk);
    chk("to_m_req", 64'(m_req), 64'(1));
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      m_addr_ok = 1'b0;
      @(negedge clk);
      chk("to_wait", 64'({err, d_done}), 64'(0));
    end
    @(posedge clk); #1;
    @(negedge clk);
    chk("to_err", 64'({err, d_done}), 64'(2'b11));

    do_txn(1'b0, 4'h0, 32'h0000_1FC0, 32'h0, 32'h55AA_55AA, 0);

    // reset while waiting in the data phase
    @(posedge clk); #1;
    d_req = 1'b1; d_wen = 4'h0; d_addr = 32'h3000;
    @(negedge clk);
    chk("rs_gnt", 64'(d_gnt), 64'(1));
    e.is_d = 1'b1; e.rdata = 32'h777; e.err = 1'b0;
    sb.push_back(e);
    @(posedge clk); #1;
    d_req = 1'b0; m_addr_ok = 1'b1;
    @(negedge clk);
    chk("rs_m_req", 64'(m_req), 64'(1));
    @(posedge clk); #1;
    m_addr_ok = 1'b0;
    @(negedge clk);
    chk("rs_data_maddr", 64'(m_addr), 64'(32'h3000));
    #2;
    rst = 1'b0;
    #1;
    chk("rs_m_req_low", 64'({m_req, m_wr, m_wstrb}), 64'(0));
    chk("rs_maddr_low", 64'(m_addr), 64'(0));
    chk("rs_outs_low", 64'({i_done, d_done, err}), 64'(0));
    chk("rs_rdata_low", 64'({i_rdata, d_rdata}), 64'(0));
    sb.delete();
    exp_d_rdata = '0;
    @(posedge clk); #1;
    rst = 1'b1; m_data_ok = 1'b1; m_rdata = 32'h777;
    @(negedge clk);
    chk("rs_late_idle", 64'({d_done, m_req}), 64'(0));
    @(posedge clk); #1;
    m_data_ok = 1'b0; m_rdata = '0;
    @(negedge clk);
    chk("rs_no_done", 64'({d_done, i_done, err}), 64'(0));
    @(posedge clk); #1;
    @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
